// File: rtl/isfet_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// isfet_seq_pkg: shared states, word layout and fill value for the
// ISFET frame sequencer.                                   Rev 1.0
// ------------------------------------------------------------------
package isfet_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW_SEL  = 3'd1,
    S_SETTLE   = 3'd2,
    S_SAMPLE   = 3'd3,
    S_WAIT_ADC = 3'd4,
    S_PUSH     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ADC_W   = 12;
  localparam int unsigned FID_W   = 4;
  localparam int unsigned WORD_W  = 32;

  localparam int unsigned ADC_LSB = 0;
  localparam int unsigned COL_LSB = 12;
  localparam int unsigned ROW_LSB = 19;
  localparam int unsigned FID_LSB = 26;
  localparam int unsigned EOF_BIT = 30;
  localparam int unsigned SOF_BIT = 31;

  localparam logic [ADC_W-1:0] ADC_TIMEOUT_FILL = 12'hFFF;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic              sof,
    input logic              eof,
    input logic [FID_W-1:0]  fid,
    input logic [ADDR_W-1:0] row,
    input logic [ADDR_W-1:0] col,
    input logic [ADC_W-1:0]  adc
  );
    logic [WORD_W-1:0] w;
    w                     = '0;
    w[SOF_BIT]            = sof;
    w[EOF_BIT]            = eof;
    w[FID_LSB +: FID_W]   = fid;
    w[ROW_LSB +: ADDR_W]  = row;
    w[COL_LSB +: ADDR_W]  = col;
    w[ADC_LSB +: ADC_W]   = adc;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isfet_frame_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// isfet_frame_sequencer: row/column ISFET scan, ADC strobe/collect,
// tagged pixel words out with ready/valid.                 Rev 1.0
// ------------------------------------------------------------------
module isfet_frame_sequencer
  import isfet_seq_pkg::*;
#(
  parameter int unsigned ROWS          = 78,
  parameter int unsigned COLS          = 56,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ADC_TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               row_en,
  output logic [ADDR_W-1:0]  row_addr,
  output logic [ADDR_W-1:0]  col_addr,
  output logic               sample_strobe,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   adc_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic               frame_done,
  output logic               err_timeout,
  output logic               err_start_miss
);

  localparam int unsigned CNT_W = 16;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   row_q, col_q;
  logic [FID_W-1:0]    frame_id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                row_en_q, strobe_q, out_valid_q, busy_q, done_q;
  logic                err_to_q, err_miss_q;
  logic [WORD_W-1:0]   out_data_q;
  logic                is_first, is_last;

  assign is_first = (row_q == '0) && (col_q == '0);
  assign is_last  = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      frame_id_q  <= '0;
      cnt_q       <= '0;
      row_en_q    <= 1'b0;
      strobe_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_miss_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (start && (state_q != S_IDLE)) begin
        err_miss_q <= 1'b1;
      end
      if (abort) begin
        // Any pending word is dropped; the frame simply never completes.
        state_q     <= S_IDLE;
        row_q       <= '0;
        col_q       <= '0;
        row_en_q    <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_ROW_SEL;
              row_q      <= '0;
              col_q      <= '0;
              frame_id_q <= frame_id_q + 4'd1;
              busy_q     <= 1'b1;
              row_en_q   <= 1'b1;
            end
          end
          S_ROW_SEL: begin
            row_en_q <= 1'b1;
            cnt_q    <= CNT_W'(SETTLE_CYCLES);
            state_q  <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_q    <= '0;
              strobe_q <= 1'b1;
              state_q  <= S_SAMPLE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            cnt_q   <= CNT_W'(ADC_TIMEOUT);
            state_q <= S_WAIT_ADC;
          end
          S_WAIT_ADC: begin
            if (adc_valid) begin
              out_data_q  <= pack_word(is_first, is_last, frame_id_q, row_q, col_q, adc_data);
              out_valid_q <= 1'b1;
              state_q     <= S_PUSH;
            end else if (cnt_q <= CNT_W'(1)) begin
              err_to_q    <= 1'b1;
              out_data_q  <= pack_word(is_first, is_last, frame_id_q, row_q, col_q,
                                       ADC_TIMEOUT_FILL);
              out_valid_q <= 1'b1;
              state_q     <= S_PUSH;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_PUSH: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (col_q != LAST_COL) begin
                col_q    <= col_q + ADDR_W'(1);
                strobe_q <= 1'b1;
                state_q  <= S_SAMPLE;
              end else if (row_q != LAST_ROW) begin
                // row_en drops for the ROW_SEL cycle and returns on entry to SETTLE.
                col_q    <= '0;
                row_q    <= row_q + ADDR_W'(1);
                row_en_q <= 1'b0;
                state_q  <= S_ROW_SEL;
              end else begin
                row_en_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign row_en         = row_en_q;
  assign row_addr       = row_q;
  assign col_addr       = col_q;
  assign sample_strobe  = strobe_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign err_timeout    = err_to_q;
  assign err_start_miss = err_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_isfet_frame_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_isfet_frame_sequencer: directed frames on a 2x3 array with
// hand-derived word contents and cycle positions.          Rev 1.0
// ------------------------------------------------------------------
module tb_isfet_frame_sequencer;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int ST = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        out_ready = 1'b1;
  logic        row_en, sample_strobe, out_valid, busy, frame_done;
  logic        err_timeout, err_start_miss;
  logic [6:0]  row_addr, col_addr;
  logic [31:0] out_data;

  isfet_frame_sequencer #(
    .ROWS(R), .COLS(C), .SETTLE_CYCLES(ST), .ADC_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .row_en(row_en), .row_addr(row_addr), .col_addr(col_addr),
    .sample_strobe(sample_strobe), .adc_valid(adc_valid), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_start_miss(err_start_miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_fid = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] adc_model(input logic [3:0] f, input int r, input int c);
    return {f, 4'(r), 4'(c)} ^ 12'h5A3;
  endfunction

  // Word layout: {sof, eof, fid[3:0], row[6:0], col[6:0], adc[11:0]}
  function automatic logic [31:0] exp_word(input int idx, input bit timed_out);
    logic [11:0] a;
    a = timed_out ? 12'hFFF : adc_model(exp_fid, idx / C, idx % C);
    return {idx == 0, idx == R*C-1, exp_fid, 7'(idx / C), 7'(idx % C), a};
  endfunction

  // Indices select which word gets backpressure, an ADC timeout, a stray start or an abort.
  task automatic run_frame(input int bp_idx, input int to_idx, input int miss_idx, input int abort_idx);
    int          widx, j, strobe_j, bp_left;
    bit          pend_adc, seen_cur, hs_pend, first_seen;
    logic [11:0] pend_data;
    logic [31:0] held;
    widx = 0; j = 0; strobe_j = 0; bp_left = 0;
    pend_adc = 0; seen_cur = 0; hs_pend = 0; first_seen = 0;
    pend_data = '0; held = '0;
    exp_fid = exp_fid + 4'd1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_on", busy, 1);
    check_eq("row_en_on", row_en, 1);
    forever begin
      if (j > 400) begin
        check_eq("cycle_budget", 0, 1);
        return;
      end
      start = 1'b0;
      adc_valid = 1'b0;
      if (hs_pend) begin
        hs_pend = 0;
        seen_cur = 0;
        if (widx == R*C-1) begin
          check_eq("frame_done", frame_done, 1);
          check_eq("valid_drop", out_valid, 0);
          step();
          check_eq("idle_busy", busy, 0);
          check_eq("done_pulse", frame_done, 0);
          return;
        end else if ((widx % C) == C-1) begin
          check_eq("row_gap", row_en, 0);
        end else begin
          check_eq("hs_to_strobe", sample_strobe, 1);
        end
        widx++;
      end
      if (pend_adc) begin
        adc_valid = 1'b1;
        adc_data  = pend_data;
        pend_adc  = 0;
      end
      if (sample_strobe) begin
        if (!first_seen) begin
          first_seen = 1;
          check_eq("first_strobe", j, ST + 1);
        end
        check_eq("strobe_row", row_addr, widx / C);
        check_eq("strobe_col", col_addr, widx % C);
        strobe_j = j;
        if (widx != to_idx) begin
          pend_adc  = 1;
          pend_data = adc_model(exp_fid, widx / C, widx % C);
        end
      end
      if (out_valid) begin
        if (!seen_cur) begin
          seen_cur = 1;
          held = out_data;
          check_eq("word", out_data, exp_word(widx, widx == to_idx));
          if (widx == to_idx) begin
            check_eq("timeout_gap", j - strobe_j, TO + 1);
            check_eq("err_timeout", err_timeout, 1);
          end
          if (widx == bp_idx) bp_left = 5;
          if (widx == miss_idx) start = 1'b1;
          if (widx == abort_idx) begin
            abort = 1'b1;
            out_ready = 1'b0;
            step();
            abort = 1'b0;
            out_ready = 1'b1;
            check_eq("abort_valid", out_valid, 0);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_row_en", row_en, 0);
            check_eq("abort_strobe", sample_strobe, 0);
            for (int k = 0; k < 3; k++) begin
              step();
              check_eq("abort_no_done", frame_done, 0);
            end
            return;
          end
        end else begin
          check_eq("word_hold", out_data, held);
          check_eq("hold_no_strobe", sample_strobe, 0);
        end
        if (bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
        end
        hs_pend = out_ready;
      end
      step();
      j++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("reset_data", out_data, 0);
    check_eq("reset_ctl", {row_en, row_addr, col_addr, sample_strobe, out_valid, busy,
                           frame_done, err_timeout, err_start_miss}, 0);
    rst_n = 1'b1;
    step();

    run_frame(-1, -1, -1, -1);
    check_eq("miss_clear", err_start_miss, 0);
    check_eq("timeout_clear", err_timeout, 0);

    run_frame(1, -1, 3, -1);
    check_eq("start_miss", err_start_miss, 1);

    run_frame(-1, 3, -1, -1);
    check_eq("timeout_sticky", err_timeout, 1);

    run_frame(-1, -1, -1, 2);

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_beats_start", busy, 0);
    step();

    run_frame(-1, -1, -1, -1);

    while (exp_fid != 4'd13) run_frame(-1, -1, -1, -1);
    repeat (4) run_frame(-1, -1, -1, -1);
    check_eq("fid_wrapped", exp_fid, 4'd1);
    check_eq("sticky_errs", {err_timeout, err_start_miss}, 2'b11);

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check_eq("midreset_data", out_data, 0);
    check_eq("midreset_ctl", {row_en, row_addr, col_addr, sample_strobe, out_valid, busy,
                              frame_done, err_timeout, err_start_miss}, 0);
    rst_n = 1'b1;
    step();
    exp_fid = 4'd0;
    run_frame(-1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
